// File: rtl/register_file_arbiter_if.sv
// Bus bundle between the register file arbiter, its two requesters and the 256x8 register file.
// Handshake: a requester raises reqN with weN/wordN/addrN/wdataN and holds all of them stable until
// ackN; ackN is a single-cycle strobe with rdataN valid alongside it, and reqN may carry a new request in that cycle.
interface register_file_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                    req0;
  logic                    we0;
  logic                    word0;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [2*DATA_WIDTH-1:0] wdata0;
  logic                    ack0;
  logic [2*DATA_WIDTH-1:0] rdata0;

  logic                    req1;
  logic                    we1;
  logic                    word1;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [2*DATA_WIDTH-1:0] wdata1;
  logic                    ack1;
  logic [2*DATA_WIDTH-1:0] rdata1;

  logic                    ram_write_en;
  logic [ADDR_WIDTH-1:0]   ram_address;
  logic [DATA_WIDTH-1:0]   ram_data_in;
  logic [DATA_WIDTH-1:0]   ram_data_out;

  logic                    busy;
  logic [1:0]              dbg_state;

  modport slave (
    input  req0, we0, word0, addr0, wdata0,
    input  req1, we1, word1, addr1, wdata1,
    input  ram_data_out,
    output ack0, rdata0, ack1, rdata1,
    output ram_write_en, ram_address, ram_data_in,
    output busy, dbg_state
  );

  modport master (
    output req0, we0, word0, addr0, wdata0,
    output req1, we1, word1, addr1, wdata1,
    output ram_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  ram_write_en, ram_address, ram_data_in,
    input  busy, dbg_state
  );
endinterface

// File: rtl/register_file_arbiter.sv
// Round-robin arbiter sharing a single-port, synchronous-read register file between two requesters.
// Words are big-endian register pairs {even, odd}; each request takes one (byte) or two (word) RAM cycles.
module register_file_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  register_file_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_HI = 2'd1,
    ACC_LO = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_owner;
  logic                    r_last_grant;
  logic                    r_we;
  logic                    r_word;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2*DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0]   r_hi_byte;
  logic                    r_ack0;
  logic                    r_ack1;
  logic [2*DATA_WIDTH-1:0] r_rdata0;
  logic [2*DATA_WIDTH-1:0] r_rdata1;

  logic                    w_any_req;
  logic                    w_grant;
  logic                    w_sel_we;
  logic                    w_sel_word;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [2*DATA_WIDTH-1:0] w_sel_wdata;
  logic [2*DATA_WIDTH-1:0] w_result;

  // On a tie the port that did not win last time gets the grant.
  assign w_any_req   = bus.req0 | bus.req1;
  assign w_grant     = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;
  assign w_sel_we    = w_grant ? bus.we1    : bus.we0;
  assign w_sel_word  = w_grant ? bus.word1  : bus.word0;
  assign w_sel_addr  = w_grant ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_grant ? bus.wdata1 : bus.wdata0;

  // In FINISH the RAM output holds the byte read in the last access cycle.
  assign w_result = r_word ? {r_hi_byte, bus.ram_data_out}
                           : {{DATA_WIDTH{1'b0}}, bus.ram_data_out};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_word       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hi_byte    <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_we    <= w_sel_we;
            r_word  <= w_sel_word;
            r_addr  <= w_sel_word ? {w_sel_addr[ADDR_WIDTH-1:1], 1'b0} : w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= ACC_HI;
          end
        end
        ACC_HI: r_state <= r_word ? ACC_LO : FINISH;
        ACC_LO: begin
          r_hi_byte <= bus.ram_data_out;
          r_state   <= FINISH;
        end
        FINISH: begin
          if (r_owner) begin
            r_rdata1 <= w_result;
            r_ack1   <= 1'b1;
          end else begin
            r_rdata0 <= w_result;
            r_ack0   <= 1'b1;
          end
          r_last_grant <= r_owner;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM controls are decoded from state so reset drops the write strobe at once.
  always_comb begin
    bus.ram_write_en = 1'b0;
    bus.ram_address  = '0;
    bus.ram_data_in  = '0;
    case (r_state)
      ACC_HI: begin
        bus.ram_write_en = r_we;
        bus.ram_address  = r_addr;
        bus.ram_data_in  = r_word ? r_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : r_wdata[DATA_WIDTH-1:0];
      end
      ACC_LO: begin
        bus.ram_write_en = r_we;
        bus.ram_address  = {r_addr[ADDR_WIDTH-1:1], 1'b1};
        bus.ram_data_in  = r_wdata[DATA_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_register_file_arbiter.sv
// Directed bench for register_file_arbiter: a 256x8 sync-read register file model, per-port
// request drivers, expected-rdata queues, and one summary line at the end.
module tb_register_file_arbiter;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  register_file_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  register_file_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: synchronous read, read-before-write on the same edge
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clock) begin
    bus.ram_data_out <= mem[bus.ram_address];
    if (bus.ram_write_en) mem[bus.ram_address] <= bus.ram_data_in;
  end

  // Scoreboard: expected read data per port
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  // Per-cycle trace captured while waiting for an ack (index = cycles after the request edge)
  logic [7:0] seen_addr [16];
  logic [7:0] seen_din  [16];
  logic       seen_we   [16];
  logic       seen_busy [16];
  int         n_we;

  // Race tables: byte reads each port issues back to back
  logic [7:0]  ra0 [4];
  logic [7:0]  ra1 [4];
  logic [15:0] re0 [4];
  logic [15:0] re1 [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int p, input logic we, input logic word, input logic [7:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.word0 = word; bus.addr0 = addr; bus.wdata0 = wdata;
      exp_q0.push_back(exp);
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.word1 = word; bus.addr1 = addr; bus.wdata1 = wdata;
      exp_q1.push_back(exp);
    end
  endtask

  // Called at a negedge right after issue(); returns at the negedge of the ack cycle with req dropped.
  task automatic wait_ack(input int p, input int exp_lat, input string tag);
    int          cyc;
    logic        got;
    logic [15:0] exp;
    logic [15:0] rd;
    cyc  = 0;
    got  = 1'b0;
    n_we = 0;
    for (int i = 0; i < 16; i++) begin
      seen_addr[i] = 8'h00; seen_din[i] = 8'h00; seen_we[i] = 1'b0; seen_busy[i] = 1'b0;
    end
    while (!got && cyc < 12) begin
      @(negedge clock);
      cyc++;
      seen_addr[cyc] = bus.ram_address;
      seen_din[cyc]  = bus.ram_data_in;
      seen_we[cyc]   = bus.ram_write_en;
      seen_busy[cyc] = bus.busy;
      if (bus.ram_write_en) n_we++;
      got = (p == 0) ? bus.ack0 : bus.ack1;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    if (p == 0) begin
      exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 16'hxxxx;
      rd  = bus.rdata0;
      check({tag, "_other_ack"}, {31'b0, bus.ack1}, 0);
      bus.req0 = 1'b0;
    end else begin
      exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 16'hxxxx;
      rd  = bus.rdata1;
      check({tag, "_other_ack"}, {31'b0, bus.ack0}, 0);
      bus.req1 = 1'b0;
    end
    check({tag, "_rdata"}, rd, exp);
  endtask

  // Both ports request continuously: grants must alternate 0,1,0,1 with an ack every 3 cycles.
  task automatic race(input int n, input string tag);
    int i0, i1, k, cyc;
    i0 = 0; i1 = 0; k = 0; cyc = 0;
    issue(0, 1'b0, 1'b0, ra0[0], 16'h0000, re0[0]);
    issue(1, 1'b0, 1'b0, ra1[0], 16'h0000, re1[0]);
    while (k < 2 * n && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        check({tag, "_ack_cycle"}, cyc, 3 * (k + 1));
        check({tag, "_grant"}, {30'b0, bus.ack1, bus.ack0}, (k % 2 == 1) ? 2 : 1);
        if (bus.ack0) begin
          check({tag, "_rdata0"}, bus.rdata0, (exp_q0.size() > 0) ? exp_q0.pop_front() : 16'hxxxx);
          i0++;
          if (i0 < n) issue(0, 1'b0, 1'b0, ra0[i0], 16'h0000, re0[i0]);
          else bus.req0 = 1'b0;
        end
        if (bus.ack1) begin
          check({tag, "_rdata1"}, bus.rdata1, (exp_q1.size() > 0) ? exp_q1.pop_front() : 16'hxxxx);
          i1++;
          if (i1 < n) issue(1, 1'b0, 1'b0, ra1[i1], 16'h0000, re1[i1]);
          else bus.req1 = 1'b0;
        end
        k++;
      end
    end
    check({tag, "_ack_count"}, k, 2 * n);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.word0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 16'h0000;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.word1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 16'h0000;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_ack", {30'b0, bus.ack1, bus.ack0}, 0);
    check("rst_rdata0", bus.rdata0, 16'h0000);
    check("rst_rdata1", bus.rdata1, 16'h0000);
    check("rst_ram_ctl", {15'b0, bus.ram_write_en, bus.ram_address, bus.ram_data_in}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: byte write then byte read, port 0
    issue(0, 1'b1, 1'b0, 8'h05, 16'h00A5, 16'h0000);
    wait_ack(0, 3, "t1_bw");
    check("t1_we_cycles", n_we, 1);
    check("t1_we_addr", {seen_we[1], seen_addr[1], seen_din[1]}, {1'b1, 8'h05, 8'hA5});
    check("t1_finish_ram_idle", {seen_we[2], seen_addr[2], seen_din[2]}, 0);
    check("t1_busy", {seen_busy[1], seen_busy[2], seen_busy[3]}, 3'b110);
    check("t1_mem", mem[8'h05], 8'hA5);
    issue(0, 1'b0, 1'b0, 8'h05, 16'h0000, 16'h00A5);
    wait_ack(0, 3, "t1_br");
    check("t1_read_no_we", n_we, 0);

    // 2: word write then word read through the odd address, port 1
    issue(1, 1'b1, 1'b1, 8'h10, 16'h1234, 16'h0000);
    wait_ack(1, 4, "t2_ww");
    check("t2_we_cycles", n_we, 2);
    check("t2_hi_acc", {seen_addr[1], seen_din[1]}, 16'h1012);
    check("t2_lo_acc", {seen_addr[2], seen_din[2]}, 16'h1134);
    check("t2_mem", {mem[8'h10], mem[8'h11]}, 16'h1234);
    check("t2_rdata0_kept", bus.rdata0, 16'h00A5);
    issue(1, 1'b0, 1'b1, 8'h11, 16'h0000, 16'h1234);
    wait_ack(1, 4, "t2_wr");
    check("t2_rd_addrs", {seen_addr[1], seen_addr[2]}, 16'h1011);

    // 3: simultaneous requests from reset, four back-to-back pairs
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    ra0 = '{8'h05, 8'h11, 8'h10, 8'h05};
    re0 = '{16'h00A5, 16'h0034, 16'h0012, 16'h00A5};
    ra1 = '{8'h10, 8'h05, 8'h11, 8'h10};
    re1 = '{16'h0012, 16'h00A5, 16'h0034, 16'h0012};
    race(4, "t3");

    // 4: read-before-write on a byte
    issue(0, 1'b1, 1'b0, 8'h20, 16'h007F, 16'h0000);
    wait_ack(0, 3, "t4_w1");
    issue(0, 1'b1, 1'b0, 8'h20, 16'h0080, 16'h007F);
    wait_ack(0, 3, "t4_w2");
    check("t4_mem", mem[8'h20], 8'h80);

    // 5: reset during the low-byte cycle of a word write
    issue(1, 1'b1, 1'b1, 8'h30, 16'h1122, 16'h0000);
    wait_ack(1, 4, "t5_pre");
    issue(0, 1'b1, 1'b1, 8'h30, 16'hBEEF, 16'h0000);
    @(negedge clock);
    check("t5_acc_hi", {bus.dbg_state, bus.ram_write_en, bus.ram_address, bus.ram_data_in}, {2'd1, 1'b1, 8'h30, 8'hBE});
    @(negedge clock);
    check("t5_acc_lo", {bus.dbg_state, bus.ram_write_en, bus.ram_address, bus.ram_data_in}, {2'd2, 1'b1, 8'h31, 8'hEF});
    reset_n = 1'b0;
    #1;
    check("t5_rst_we", {31'b0, bus.ram_write_en}, 0);
    check("t5_rst_busy", {29'b0, bus.busy, bus.dbg_state}, 0);
    bus.req0 = 1'b0;
    exp_q0.delete();
    repeat (2) @(negedge clock);
    check("t5_no_ack", {30'b0, bus.ack1, bus.ack0}, 0);
    check("t5_mem", {mem[8'h30], mem[8'h31]}, 16'hBE22);
    reset_n = 1'b1;
    ra0[0] = 8'h30; re0[0] = 16'h00BE;
    ra1[0] = 8'h31; re1[0] = 16'h0022;
    race(1, "t5_tie");

    // 6: port 0 re-requests in its own ack cycle
    issue(0, 1'b0, 1'b0, 8'h05, 16'h0000, 16'h00A5);
    wait_ack(0, 3, "t6_first");
    issue(0, 1'b0, 1'b0, 8'h10, 16'h0000, 16'h0012);
    wait_ack(0, 3, "t6_second");
    check("t6_rdata1_kept", bus.rdata1, 16'h0022);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
